// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word data memory for the MEM-stage load/store
// port. Serves one read or write after a fixed latency, holding the pipeline
// with a combinational stall and finishing with a one-cycle ack pulse.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        ack_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    // Counter only has to hold LATENCY-2.
    localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        data_q;
    logic               wr_q;
    logic [31:0]        mem [DEPTH_WORDS];

    logic               req;
    logic               commit;
    logic               addr_unused;

    assign req         = mem_read_i | mem_write_i;
    assign commit      = (state == BUSY) && (count == '0);
    assign addr_unused = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

    // Stall must appear in the request cycle itself, so it is decoded
    // combinationally from the current state and the live request.
    assign stall_o = !rst_i && (((state == IDLE) && req) || (state == BUSY));

    // Control FSM: accept, count down the latency, complete with ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            count   <= '0;
            rdata_o <= '0;
            ack_o   <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        idx_q  <= addr_i[IDX_W+1:2];
                        data_q <= wdata_i;
                        wr_q   <= mem_write_i;
                        count  <= CNT_W'(LATENCY - 2);
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        if (!wr_q) begin
                            rdata_o <= mem[idx_q];
                        end
                        ack_o <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Array write port; kept reset-free so it maps onto RAM. A reset before
    // the commit edge suppresses the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && commit && wr_q) begin
            mem[idx_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: a hand-written cycle table, directed
// multi-cycle sequences and randomized traffic, all checked against a
// transaction-level reference model (accept cycle -> ack cycle arithmetic).
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 4;

    logic        clk;
    logic        rst_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        ack_o;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .mem_read_i (mem_read_i),
        .mem_write_i(mem_write_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .stall_o    (stall_o),
        .ack_o      (ack_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one transaction in flight, described by the cycle it
    // was accepted in and the cycle its ack is due.
    int          cyc;
    bit          m_busy;
    int          ack_at;
    int unsigned m_idx;
    logic [31:0] m_data;
    bit          m_wr;
    logic [31:0] m_rdata;
    logic [31:0] ref_mem [DEPTH];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          stall;
        bit          ack;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rd, bit wr, logic [31:0] addr, logic [31:0] wdata,
                                bit stall, bit ack, logic [31:0] rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.stall = stall; v.ack = ack; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample mid-cycle, then advance model.
    task automatic step(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit rst,
                        output bit s, output bit a, output logic [31:0] rdv);
        bit exp_ack;
        bit exp_stall;
        @(negedge clk);
        mem_read_i  = rd;
        mem_write_i = wr;
        addr_i      = addr;
        wdata_i     = wdata;
        rst_i       = rst;
        #1;
        exp_ack   = m_busy && (cyc == ack_at);
        exp_stall = !rst && (m_busy ? (cyc < ack_at) : (rd | wr));
        chk("stall", {31'b0, stall_o}, {31'b0, exp_stall});
        chk("ack", {31'b0, ack_o}, {31'b0, exp_ack});
        chk("rdata", rdata_o, m_rdata);
        s   = stall_o;
        a   = ack_o;
        rdv = rdata_o;
        if (rst) begin
            m_busy  = 1'b0;
            m_rdata = '0;
        end else if (m_busy) begin
            if (cyc == ack_at - 1) begin
                if (m_wr) ref_mem[m_idx] = m_data;
                else      m_rdata = ref_mem[m_idx];
            end
            if (cyc == ack_at) m_busy = 1'b0;
        end else if (rd | wr) begin
            m_busy = 1'b1;
            ack_at = cyc + int'(LAT);
            m_idx  = (addr >> 2) % DEPTH;
            m_data = wdata;
            m_wr   = wr;
        end
        cyc++;
    endtask

    // Full access from IDLE: request cycle plus LAT cycles up to and including ack.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] got);
        bit s, a;
        logic [31:0] r;
        step(rd, wr, addr, wdata, 1'b0, s, a, r);
        for (int k = 1; k <= int'(LAT); k++) begin
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, s, a, r);
            if (k == int'(LAT)) got = r;
        end
    endtask

    initial begin
        bit          s, a;
        logic [31:0] r;
        logic [31:0] got;
        int          acks;
        int          ack_pos [$];

        rst_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0;
        addr_i = '0; wdata_i = '0;
        cyc = 0; m_busy = 1'b0; m_rdata = '0; ack_at = 0;
        repeat (2) @(posedge clk);

        // Reset state.
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, s, a, r);

        // Cycle table: write, read back, write+read collision, ignored inputs while busy.
        tbl.push_back(mk(0, 1, 32'h0C, 32'hDEADBEEF, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h00, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h00, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h00, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h00, 32'h0,        0, 1, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0C, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0C, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0C, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0C, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0C, 32'h0,        0, 1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 32'h00, 32'h0,        0, 0, 32'hDEADBEEF));
        tbl.push_back(mk(1, 1, 32'h20, 32'h1,        1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 32'h00, 32'h0,        1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 32'h00, 32'h0,        1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 32'h00, 32'h0,        1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 32'h00, 32'h0,        0, 1, 32'hDEADBEEF));
        tbl.push_back(mk(1, 0, 32'h20, 32'h0,        1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 32'h20, 32'h0BAD,     1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 32'h20, 32'h0BAD,     1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 32'h20, 32'h0BAD,     1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 32'h00, 32'h0,        0, 1, 32'h1));
        tbl.push_back(mk(0, 0, 32'h00, 32'h0,        0, 0, 32'h1));
        foreach (tbl[i]) begin
            step(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0, s, a, r);
            chk($sformatf("tbl%0d_stall", i), {31'b0, s}, {31'b0, tbl[i].stall});
            chk($sformatf("tbl%0d_ack", i), {31'b0, a}, {31'b0, tbl[i].ack});
            chk($sformatf("tbl%0d_rdata", i), r, tbl[i].rdata);
        end
        chk("arr3", dut.mem[3], 32'hDEADBEEF);
        chk("arr8", dut.mem[8], 32'h1);

        // Fill every word so random reads have known contents.
        for (int i = 0; i < int'(DEPTH); i++)
            access(1'b0, 1'b1, 32'(i * 4), $urandom, got);

        // Write then read the same word at the next idle cycle.
        access(1'b0, 1'b1, 32'h40, 32'h12345678, got);
        access(1'b1, 1'b0, 32'h40, 32'h0, got);
        chk("raw_rdata", got, 32'h12345678);
        chk("arr16", dut.mem[16], 32'h12345678);

        // Address wrap modulo DEPTH*4 and ignored byte offset.
        access(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, got);
        access(1'b1, 1'b0, 32'h000, 32'h0, got);
        chk("wrap_rdata", got, 32'hA5A5A5A5);
        access(1'b1, 1'b0, 32'h403, 32'h0, got);
        chk("offset_rdata", got, 32'hA5A5A5A5);

        // Reset two cycles into a write aborts it.
        access(1'b0, 1'b1, 32'h8, 32'h55, got);
        step(1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 1'b0, s, a, r);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, s, a, r);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, s, a, r);
        chk("rst_stall", {31'b0, s}, 32'h0);
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, s, a, r);
            if (a) acks++;
        end
        chk("abort_acks", acks, 32'h0);
        chk("abort_arr2", dut.mem[2], 32'h55);
        access(1'b1, 1'b0, 32'h8, 32'h0, got);
        chk("abort_read", got, 32'h55);

        // Read held continuously: acks at offsets LAT and 2*LAT+1 only.
        acks = 0;
        ack_pos.delete();
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 32'h0C, 32'h0, 1'b0, s, a, r);
            if (a) begin
                acks++;
                ack_pos.push_back(k);
            end
        end
        chk("held_acks", acks, 32'd2);
        if (ack_pos.size() == 2) begin
            chk("held_ack0", ack_pos[0], 32'(LAT));
            chk("held_ack1", ack_pos[1], 32'(2 * LAT + 1));
        end else begin
            chk("held_ack_count", ack_pos.size(), 32'd2);
        end
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, s, a, r);

        // Randomized traffic, including occasional resets.
        for (int k = 0; k < 3000; k++) begin
            bit rd, wr, rs;
            rd = ($urandom_range(0, 2) == 0);
            wr = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 59) == 0);
            step(rd, wr, $urandom, $urandom, rs, s, a, r);
        end
        repeat (LAT + 2) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, s, a, r);

        // Array contents must match the model word for word.
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(DEPTH); i++)
            chk($sformatf("arr_final%0d", i), dut.mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
